// File: rtl/scan_dump_sequencer.sv
// Scan-chain dump sequencer.
// Walks the selected chains in ascending order. For each chain it sends a header
// byte and an index byte, then packs the chain's serial bits LSB-first into data
// bytes. It ends each chain with a 16-bit bit-count trailer, high byte first.
// All bytes go out through the shared UART using a single issue/hand-off handshake.
module scan_dump_sequencer #(
    parameter int         NUM_CH   = 8,
    parameter logic [7:0] HDR_BYTE = 8'hA5,
    parameter logic       PAD_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] dump_en,
    input  logic [NUM_CH-1:0] ch_out,
    input  logic [NUM_CH-1:0] ch_out_vld,
    input  logic [NUM_CH-1:0] ch_out_done,
    input  logic              uart_busy,
    output logic              tx_en,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done
);

    localparam int IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    // One extra index bit so "past the last chain" is representable.
    localparam int IXW = IW + 1;

    typedef enum logic [3:0] {
        IDLE, SEL, HDR, IDX, SHIFT, DATA, TRL_HI, TRL_LO, FIN
    } state_t;

    state_t            state, state_n;
    logic [NUM_CH-1:0] mask_r;
    logic [IXW-1:0]    idx;
    logic [IW-1:0]     sel;
    logic [15:0]       bit_cnt;
    logic [7:0]        sreg;
    logic [3:0]        nb;
    logic              last_r;
    logic              tx_guard;

    logic              can_issue;
    logic              bit_vld, bit_val, bit_last;
    logic [3:0]        nb_next;
    logic              found;
    logic [IXW-1:0]    next_idx;
    logic              issue;
    logic [7:0]        byte_n;
    logic              accept, idx_load, idx_inc, clr_chain, clr_byte;
    logic              shift_in, set_last, finish;

    assign sel      = idx[IW-1:0];
    assign bit_vld  = ch_out_vld[sel];
    assign bit_val  = ch_out[sel];
    assign bit_last = ch_out_done[sel];
    assign nb_next  = nb + {3'b000, bit_vld};

    // uart_busy only rises the cycle after tx_en, so it is not trusted while
    // tx_en is high or during the cycle that follows it.
    assign can_issue = !uart_busy && !tx_en && !tx_guard;

    // Lowest masked-in chain at or above idx; lets SEL skip gaps in one cycle.
    always_comb begin
        found    = 1'b0;
        next_idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_r[i] && (IXW'(i) >= idx)) begin
                found    = 1'b1;
                next_idx = IXW'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic, chain enable, and per-state datapath strobes.
    always_comb begin
        state_n   = state;
        issue     = 1'b0;
        byte_n    = '0;
        accept    = 1'b0;
        idx_load  = 1'b0;
        idx_inc   = 1'b0;
        clr_chain = 1'b0;
        clr_byte  = 1'b0;
        shift_in  = 1'b0;
        set_last  = 1'b0;
        finish    = 1'b0;
        dump_en   = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = SEL;
                end
            end
            SEL: begin
                if (found) begin
                    idx_load = 1'b1;
                    state_n  = HDR;
                end else begin
                    state_n = FIN;
                end
            end
            HDR: begin
                if (can_issue) begin
                    issue     = 1'b1;
                    byte_n    = HDR_BYTE;
                    clr_chain = 1'b1;
                    state_n   = IDX;
                end
            end
            IDX: begin
                if (can_issue) begin
                    issue     = 1'b1;
                    byte_n    = 8'(idx[IW-1:0]);
                    clr_chain = 1'b1;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                dump_en[sel] = 1'b1;
                shift_in     = bit_vld;
                if (bit_last) begin
                    // A final partial (or exactly full) byte is flushed once.
                    if (nb_next != 4'd0) begin
                        set_last = 1'b1;
                        state_n  = DATA;
                    end else begin
                        state_n = TRL_HI;
                    end
                end else if (nb_next == 4'd8) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (can_issue) begin
                    issue    = 1'b1;
                    byte_n   = sreg;
                    clr_byte = 1'b1;
                    state_n  = last_r ? TRL_HI : SHIFT;
                end
            end
            TRL_HI: begin
                if (can_issue) begin
                    issue   = 1'b1;
                    byte_n  = bit_cnt[15:8];
                    state_n = TRL_LO;
                end
            end
            TRL_LO: begin
                if (can_issue) begin
                    issue   = 1'b1;
                    byte_n  = bit_cnt[7:0];
                    idx_inc = 1'b1;
                    state_n = SEL;
                end
            end
            FIN: begin
                if (can_issue) begin
                    finish  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath: UART hand-off, chain index, bit packing and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r   <= '0;
            idx      <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
            nb       <= '0;
            last_r   <= 1'b0;
            tx_en    <= 1'b0;
            tx_guard <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_en    <= issue;
            tx_guard <= tx_en;
            done     <= finish;
            if (issue) begin
                tx_data <= byte_n;
            end

            if (accept) begin
                mask_r <= ch_mask;
                busy   <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end

            if (accept) begin
                idx <= '0;
            end else if (idx_load) begin
                idx <= next_idx;
            end else if (idx_inc) begin
                idx <= idx + IXW'(1);
            end

            // Refill with PAD_BIT so unused high bits of a last byte are ready.
            if (clr_chain || clr_byte) begin
                sreg <= {8{PAD_BIT}};
                nb   <= '0;
            end else if (shift_in) begin
                sreg[nb[2:0]] <= bit_val;
                nb            <= nb_next;
            end

            if (clr_chain) begin
                bit_cnt <= '0;
            end else if (shift_in && (bit_cnt != 16'hFFFF)) begin
                bit_cnt <= bit_cnt + 16'd1;
            end

            if (clr_chain) begin
                last_r <= 1'b0;
            end else if (set_last) begin
                last_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_dump_sequencer.sv
// Directed bench for scan_dump_sequencer: a UART busy model, per-chain serial
// sources, and byte / dump_en monitors checked against hand-computed streams.
module tb_scan_dump_sequencer;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] ch_mask, dump_en, ch_out, ch_out_vld, ch_out_done;
    logic       uart_busy, tx_en, busy, done;
    logic [7:0] tx_data;

    scan_dump_sequencer #(.NUM_CH(8), .HDR_BYTE(8'hA5), .PAD_BIT(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask),
        .dump_en(dump_en), .ch_out(ch_out), .ch_out_vld(ch_out_vld),
        .ch_out_done(ch_out_done), .uart_busy(uart_busy), .tx_en(tx_en),
        .tx_data(tx_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // UART model: busy for 10 cycles starting the cycle after tx_en.
    int   busy_cnt = 0;
    logic force_busy;
    assign uart_busy = force_busy || (busy_cnt != 0);
    always @(posedge clk) begin
        if (tx_en) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    // Byte capture.
    logic [7:0] rx_q[$];
    int         tx_cnt = 0;
    always @(posedge clk) begin
        if (tx_en) begin
            rx_q.push_back(tx_data);
            tx_cnt <= tx_cnt + 1;
        end
    end

    // Chain sources: chain i emits len_a[i] bits of pat_a[i], LSB first.
    int          len_a[8];
    logic [31:0] pat_a[8];
    int          ptr[8];
    logic        chain_clr;
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (chain_clr) ptr[i] <= 0;
            else if (ch_out_vld[i]) ptr[i] <= ptr[i] + 1;
        end
    end
    always_comb begin
        ch_out      = '0;
        ch_out_vld  = '0;
        ch_out_done = '0;
        for (int i = 0; i < 8; i++) begin
            if (dump_en[i]) begin
                ch_out_vld[i]  = (ptr[i] < len_a[i]);
                ch_out[i]      = pat_a[i][ptr[i][4:0]];
                ch_out_done[i] = (len_a[i] == 0) || (ptr[i] == len_a[i] - 1);
            end
        end
    end

    // dump_en monitor: distinct enabled chains per dump, and multi-hot count.
    logic [7:0] de_q[$];
    logic [7:0] de_last = '0;
    int         multi_cnt = 0;
    always @(posedge clk) begin
        if (done || rst) de_last <= '0;
        else if (dump_en != 8'h00 && dump_en != de_last) begin
            de_q.push_back(dump_en);
            de_last <= dump_en;
        end
        if (!$onehot0(dump_en)) multi_cnt <= multi_cnt + 1;
    end

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_de[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input int base);
        logic [7:0] got;
        chk({tag, "_nbytes"}, 32'(rx_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), 32'(got), 32'(exp_q[i]));
        end
    endtask

    task automatic check_de(input string tag, input int base);
        logic [7:0] got;
        chk({tag, "_nen"}, 32'(de_q.size() - base), 32'(exp_de.size()));
        for (int i = 0; i < exp_de.size(); i++) begin
            got = (base + i < de_q.size()) ? de_q[base + i] : 8'hxx;
            chk($sformatf("%s_en%0d", tag, i), 32'(got), 32'(exp_de[i]));
        end
    endtask

    task automatic pulse_chain_clr();
        @(negedge clk); chain_clr = 1'b1;
        @(negedge clk); chain_clr = 1'b0;
    endtask

    task automatic set_chain(input int i, input int len, input logic [31:0] pat);
        len_a[i] = len;
        pat_a[i] = pat;
    endtask

    // Wait (bounded) for the done pulse; poke_at >= 1 re-pulses start mid-dump.
    task automatic wait_done(input string tag, input int poke_at, input int budget,
                             output int cycles);
        cycles = 1;
        while (!done && cycles < budget) begin
            if (cycles == poke_at) begin start = 1'b1; ch_mask = 8'hFF; end
            @(negedge clk);
            start = 1'b0; ch_mask = '0;
            cycles++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    task automatic run_dump(input string tag, input logic [7:0] mask, input int poke_at,
                            input int budget, output int cycles);
        @(negedge clk); ch_mask = mask; start = 1'b1;
        @(negedge clk); start = 1'b0; ch_mask = '0;
        chk({tag, "_busy_on_start"}, 32'(busy), 32'd1);
        wait_done(tag, poke_at, budget, cycles);
    endtask

    int base_rx, base_de, cyc, n, t0;

    initial begin
        rst = 1'b1; start = 1'b0; ch_mask = '0; force_busy = 1'b0; chain_clr = 1'b1;
        for (int i = 0; i < 8; i++) begin len_a[i] = 0; pat_a[i] = '0; end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dump_en", 32'(dump_en), 32'd0);
        chk("rst_tx_en",   32'(tx_en),   32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_done",    32'(done),    32'd0);
        @(negedge clk); rst = 1'b0; chain_clr = 1'b0;

        // Chain 0: 16 bits alternating 1,0,... -> two full bytes, done on 16th.
        set_chain(0, 16, 32'h0000_5555);
        pulse_chain_clr();
        base_rx = rx_q.size(); base_de = de_q.size();
        run_dump("t1", 8'h01, -1, 600, cyc);
        exp_q = '{8'hA5, 8'h00, 8'h55, 8'h55, 8'h00, 8'h10};
        check_bytes("t1", base_rx);
        exp_de = '{8'h01};
        check_de("t1", base_de);

        // Chain 2: 11 ones -> FF then padded 07; start re-pulsed while busy.
        set_chain(2, 11, 32'h0000_07FF);
        pulse_chain_clr();
        base_rx = rx_q.size(); base_de = de_q.size();
        run_dump("t2", 8'h04, 20, 600, cyc);
        exp_q = '{8'hA5, 8'h02, 8'hFF, 8'h07, 8'h00, 8'h0B};
        check_bytes("t2", base_rx);
        exp_de = '{8'h04};
        check_de("t2", base_de);

        // Chains 1 and 3: exactly 8 bits each, done on the 8th bit -> no pad byte.
        set_chain(1, 8, 32'h0000_003C);
        set_chain(3, 8, 32'h0000_00C3);
        pulse_chain_clr();
        base_rx = rx_q.size(); base_de = de_q.size();
        run_dump("t3", 8'h0A, -1, 900, cyc);
        exp_q = '{8'hA5, 8'h01, 8'h3C, 8'h00, 8'h08, 8'hA5, 8'h03, 8'hC3, 8'h00, 8'h08};
        check_bytes("t3", base_rx);
        exp_de = '{8'h02, 8'h08};
        check_de("t3", base_de);

        // UART held busy across the first data byte send.
        pulse_chain_clr();
        base_rx = rx_q.size();
        @(negedge clk); ch_mask = 8'h01; start = 1'b1;
        @(negedge clk); start = 1'b0; ch_mask = '0;
        n = 0;
        while (dump_en == 8'h00 && n < 200) begin @(negedge clk); n++; end
        chk("t4_shift_reached", 32'(dump_en), 32'h01);
        force_busy = 1'b1;
        n = 0;
        while (dump_en != 8'h00 && n < 50) begin @(negedge clk); n++; end
        chk("t4_shift_left", 32'(dump_en), 32'h00);
        t0 = tx_cnt; n = 0;
        repeat (200) begin
            @(negedge clk);
            if (dump_en != 8'h00) n++;
        end
        chk("t4_no_tx_while_busy", 32'(tx_cnt - t0), 32'd0);
        chk("t4_no_en_while_busy", 32'(n), 32'd0);
        force_busy = 1'b0;
        t0 = tx_cnt;
        repeat (8) @(negedge clk);
        chk("t4_one_tx_after_release", 32'(tx_cnt - t0), 32'd1);
        wait_done("t4", -1, 600, cyc);
        exp_q = '{8'hA5, 8'h00, 8'h55, 8'h55, 8'h00, 8'h10};
        check_bytes("t4", base_rx);

        // Reset in the middle of SHIFT, then a clean restart.
        pulse_chain_clr();
        @(negedge clk); ch_mask = 8'h01; start = 1'b1;
        @(negedge clk); start = 1'b0; ch_mask = '0;
        n = 0;
        while (dump_en == 8'h00 && n < 200) begin @(negedge clk); n++; end
        chk("t5_shift_reached", 32'(dump_en), 32'h01);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_rst_dump_en", 32'(dump_en), 32'd0);
        chk("t5_rst_busy",    32'(busy),    32'd0);
        chk("t5_rst_tx_en",   32'(tx_en),   32'd0);
        @(negedge clk); rst = 1'b0;
        pulse_chain_clr();
        base_rx = rx_q.size(); base_de = de_q.size();
        run_dump("t5", 8'h01, -1, 600, cyc);
        exp_q = '{8'hA5, 8'h00, 8'h55, 8'h55, 8'h00, 8'h10};
        check_bytes("t5", base_rx);
        exp_de = '{8'h01};
        check_de("t5", base_de);

        // Empty mask: no bytes, done within 3 cycles of start.
        t0 = tx_cnt;
        run_dump("t6", 8'h00, -1, 3, cyc);
        chk("t6_done_latency_le3", 32'(cyc <= 3), 32'd1);
        chk("t6_no_tx", 32'(tx_cnt - t0), 32'd0);

        chk("dump_en_never_multi_hot", 32'(multi_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
